alu_ctrl_seq: RTL and testbench

- Registered ALU-control decoder with a multi-cycle multiply/divide sequencer, for the MIPS execute stage.
- Maps opcode and R-type funct to the ALU fncode, using the package FUNCT_* and OPCODE_* constants.
- Adds a valid/ready handshake, one-cycle registered latency, and MULT/MULTU/DIV/DIVU sequencing with HI/LO write strobe and stall.
- Also adds flush and illegal-instruction flagging.

---
 rtl/alu_ctrl_if.sv | 25 ++
 rtl/alu_ctrl_seq.sv | 150 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_if.sv
// Handshake and result bundle between the MIPS execute-stage control logic and
// the ALU-control decoder/mult-div sequencer.
interface alu_ctrl_if;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] opcode;
  logic [5:0] rtype_fncode;
  logic       out_valid;
  logic [5:0] fncode;
  logic       illegal;
  logic       md_start;
  logic       md_busy;
  logic       hilo_we;

  modport master (
    output flush, in_valid, opcode, rtype_fncode,
    input  in_ready, out_valid, fncode, illegal, md_start, md_busy, hilo_we
  );

  modport slave (
    input  flush, in_valid, opcode, rtype_fncode,
    output in_ready, out_valid, fncode, illegal, md_start, md_busy, hilo_we
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered MIPS ALU-control decoder with a multi-cycle MULT/DIV sequencer that
// stalls upstream while busy and strobes the HI/LO write at completion.
module alu_ctrl_seq #(
  parameter int         MULT_CYCLES    = 4,
  parameter int         DIV_CYCLES     = 33,
  parameter logic [5:0] ILLEGAL_FNCODE = 6'h3F
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_ctrl_if.slave  bus
);

  localparam logic [5:0] OPCODE_RTYPE  = 6'h00;
  localparam logic [5:0] OPCODE_REGIMM = 6'h01;
  localparam logic [5:0] OPCODE_BEQ    = 6'h04;
  localparam logic [5:0] OPCODE_BNE    = 6'h05;
  localparam logic [5:0] OPCODE_BLEZ   = 6'h06;
  localparam logic [5:0] OPCODE_BGTZ   = 6'h07;
  localparam logic [5:0] OPCODE_ADDIU  = 6'h09;
  localparam logic [5:0] OPCODE_SLTI   = 6'h0A;
  localparam logic [5:0] OPCODE_SLTIU  = 6'h0B;
  localparam logic [5:0] OPCODE_ANDI   = 6'h0C;
  localparam logic [5:0] OPCODE_ORI    = 6'h0D;
  localparam logic [5:0] OPCODE_XORI   = 6'h0E;
  localparam logic [5:0] OPCODE_LB     = 6'h20;
  localparam logic [5:0] OPCODE_LH     = 6'h21;
  localparam logic [5:0] OPCODE_LWL    = 6'h22;
  localparam logic [5:0] OPCODE_LW     = 6'h23;
  localparam logic [5:0] OPCODE_LBU    = 6'h24;
  localparam logic [5:0] OPCODE_LHU    = 6'h25;
  localparam logic [5:0] OPCODE_LWR    = 6'h26;
  localparam logic [5:0] OPCODE_SB     = 6'h28;
  localparam logic [5:0] OPCODE_SH     = 6'h29;
  localparam logic [5:0] OPCODE_SW     = 6'h2B;

  localparam logic [5:0] FUNCT_MULT    = 6'h18;
  localparam logic [5:0] FUNCT_MULTU   = 6'h19;
  localparam logic [5:0] FUNCT_DIV     = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU    = 6'h1B;
  localparam logic [5:0] FUNCT_ADDU    = 6'h21;
  localparam logic [5:0] FUNCT_SUBU    = 6'h23;
  localparam logic [5:0] FUNCT_AND     = 6'h24;
  localparam logic [5:0] FUNCT_OR      = 6'h25;
  localparam logic [5:0] FUNCT_XOR     = 6'h26;
  localparam logic [5:0] FUNCT_SLT     = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU    = 6'h2B;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  // The counter is loaded with L-1 so that BUSY spans exactly L cycles.
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          accept;
  logic [5:0]    dec_fn;
  logic          dec_ill;
  logic          is_md;
  logic          is_div;

  assign bus.in_ready = (state == IDLE) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    dec_fn  = ILLEGAL_FNCODE;
    dec_ill = 1'b0;
    is_md   = 1'b0;
    is_div  = 1'b0;
    unique case (bus.opcode)
      OPCODE_RTYPE: begin
        dec_fn = bus.rtype_fncode;
        is_md  = (bus.rtype_fncode == FUNCT_MULT) || (bus.rtype_fncode == FUNCT_MULTU) ||
                 (bus.rtype_fncode == FUNCT_DIV)  || (bus.rtype_fncode == FUNCT_DIVU);
        is_div = (bus.rtype_fncode == FUNCT_DIV)  || (bus.rtype_fncode == FUNCT_DIVU);
      end
      OPCODE_ADDIU, OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU, OPCODE_LW,
      OPCODE_LWL, OPCODE_LWR, OPCODE_SW, OPCODE_SH, OPCODE_SB: dec_fn = FUNCT_ADDU;
      OPCODE_ANDI:  dec_fn = FUNCT_AND;
      OPCODE_ORI:   dec_fn = FUNCT_OR;
      OPCODE_XORI:  dec_fn = FUNCT_XOR;
      OPCODE_SLTI:  dec_fn = FUNCT_SLT;
      OPCODE_SLTIU: dec_fn = FUNCT_SLTU;
      OPCODE_BEQ, OPCODE_BNE: dec_fn = FUNCT_SUBU;
      // Branches against zero use a signed compare.
      OPCODE_BLEZ, OPCODE_BGTZ, OPCODE_REGIMM: dec_fn = FUNCT_SLT;
      default:      dec_ill = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      count         <= '0;
      bus.out_valid <= 1'b0;
      bus.fncode    <= '0;
      bus.illegal   <= 1'b0;
      bus.md_start  <= 1'b0;
      bus.md_busy   <= 1'b0;
      bus.hilo_we   <= 1'b0;
    end else if (bus.flush) begin
      // fncode/illegal keep their last value; only the strobes and state are dropped.
      state         <= IDLE;
      count         <= '0;
      bus.out_valid <= 1'b0;
      bus.md_start  <= 1'b0;
      bus.md_busy   <= 1'b0;
      bus.hilo_we   <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.md_start  <= 1'b0;
      bus.hilo_we   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            bus.fncode  <= dec_fn;
            bus.illegal <= dec_ill;
            if (is_md) begin
              state        <= BUSY;
              bus.md_start <= 1'b1;
              bus.md_busy  <= 1'b1;
              count        <= is_div ? DIV_LOAD : MULT_LOAD;
            end else begin
              bus.out_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (count == '0) begin
            state         <= DONE;
            bus.md_busy   <= 1'b0;
            bus.hilo_we   <= 1'b1;
            bus.out_valid <= 1'b1;
          end else begin
            count <= count - CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench: two builds (default latencies and MULT=1/DIV=2) share one
// stimulus stream and are each compared against a cycle-schedule reference model.
module tb_alu_ctrl_seq;

  localparam int NC = 2048;
  localparam int LM[2] = '{4, 1};
  localparam int LD[2] = '{33, 2};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush;
  logic       in_valid;
  logic [5:0] opcode;
  logic [5:0] rtype_fncode;

  alu_ctrl_if bus0 ();
  alu_ctrl_if bus1 ();

  assign bus0.flush = flush;  assign bus0.in_valid = in_valid;
  assign bus0.opcode = opcode; assign bus0.rtype_fncode = rtype_fncode;
  assign bus1.flush = flush;  assign bus1.in_valid = in_valid;
  assign bus1.opcode = opcode; assign bus1.rtype_fncode = rtype_fncode;

  alu_ctrl_seq dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  alu_ctrl_seq #(.MULT_CYCLES(1), .DIV_CYCLES(2)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  always #5 clk = ~clk;

  logic [1:0] o_rdy, o_ov, o_ill, o_start, o_busy, o_hilo;
  logic [5:0] o_fn[2];
  assign o_rdy   = {bus1.in_ready,  bus0.in_ready};
  assign o_ov    = {bus1.out_valid, bus0.out_valid};
  assign o_ill   = {bus1.illegal,   bus0.illegal};
  assign o_start = {bus1.md_start,  bus0.md_start};
  assign o_busy  = {bus1.md_busy,   bus0.md_busy};
  assign o_hilo  = {bus1.hilo_we,   bus0.hilo_we};
  assign o_fn[0] = bus0.fncode;
  assign o_fn[1] = bus1.fncode;

  // Expected-output schedule indexed by absolute cycle number.
  bit         e_ov[2][NC], e_hilo[2][NC], e_start[2][NC], e_busy[2][NC];
  bit         fn_set[2][NC], e_ill[2][NC];
  logic [5:0] e_fn[2][NC];
  int         ready_from[2];
  logic [5:0] cur_fn[2];
  bit         cur_ill[2];
  bit         model_on = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input int d, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d cycle %0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn_in,
                                     output logic [5:0] f, output bit ill, output int lat);
    ill = 1'b0;
    lat = 0;
    case (op)
      6'h00: begin
        f = fn_in;
        if (fn_in inside {6'h18, 6'h19}) lat = 1;
        if (fn_in inside {6'h1A, 6'h1B}) lat = 2;
      end
      6'h09, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
      6'h28, 6'h29, 6'h2B: f = 6'h21;
      6'h0C: f = 6'h24;
      6'h0D: f = 6'h25;
      6'h0E: f = 6'h26;
      6'h0A: f = 6'h2A;
      6'h0B: f = 6'h2B;
      6'h04, 6'h05: f = 6'h23;
      6'h06, 6'h07, 6'h01: f = 6'h2A;
      default: begin f = 6'h3F; ill = 1'b1; end
    endcase
  endfunction

  task automatic clear_after(input int d, input int c);
    for (int k = c + 1; k < NC; k++) begin
      e_ov[d][k] = 0; e_hilo[d][k] = 0; e_start[d][k] = 0; e_busy[d][k] = 0;
    end
  endtask

  // One clock cycle: check cycle outputs, advance the model across the edge, clock.
  task automatic tick();
    logic [5:0] f;
    bit         ill;
    int         lat, len;
    bit         rdy;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (model_on) begin
        if (fn_set[d][cyc]) begin cur_fn[d] = e_fn[d][cyc]; cur_ill[d] = e_ill[d][cyc]; end
        check("out_valid", d, 6'(o_ov[d]),    6'(e_ov[d][cyc]));
        check("hilo_we",   d, 6'(o_hilo[d]),  6'(e_hilo[d][cyc]));
        check("md_start",  d, 6'(o_start[d]), 6'(e_start[d][cyc]));
        check("md_busy",   d, 6'(o_busy[d]),  6'(e_busy[d][cyc]));
        check("fncode",    d, o_fn[d],        cur_fn[d]);
        check("illegal",   d, 6'(o_ill[d]),   6'(cur_ill[d]));
      end
      if (!reset_n) begin
        clear_after(d, cyc);
        for (int k = cyc + 1; k < NC; k++) fn_set[d][k] = 0;
        fn_set[d][cyc+1] = 1; e_fn[d][cyc+1] = 6'h00; e_ill[d][cyc+1] = 0;
        ready_from[d] = cyc + 1;
      end else if (model_on) begin
        rdy = (cyc >= ready_from[d]) && !flush;
        check("in_ready", d, 6'(o_rdy[d]), 6'(rdy));
        if (flush) begin
          clear_after(d, cyc);
          ready_from[d] = cyc + 1;
        end else if (in_valid && rdy) begin
          ref_decode(opcode, rtype_fncode, f, ill, lat);
          fn_set[d][cyc+1] = 1; e_fn[d][cyc+1] = f; e_ill[d][cyc+1] = ill;
          if (lat == 0) begin
            e_ov[d][cyc+1] = 1;
          end else begin
            len = (lat == 1) ? LM[d] : LD[d];
            e_start[d][cyc+1] = 1;
            for (int k = 1; k <= len; k++) e_busy[d][cyc+k] = 1;
            e_ov[d][cyc+len+1]   = 1;
            e_hilo[d][cyc+len+1] = 1;
            ready_from[d] = cyc + len + 2;
          end
        end
      end
    end
    if (!reset_n) model_on = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input bit v, input logic [5:0] op, input logic [5:0] fn, input bit fl, input int n);
    in_valid = v; opcode = op; rtype_fncode = fn; flush = fl;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [5:0] md_fn[4];
    md_fn = '{6'h18, 6'h19, 6'h1A, 6'h1B};
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; opcode = '0; rtype_fncode = '0;
    #1;
    drive(0, 6'h00, 6'h00, 0, 2);
    reset_n = 1'b1;
    drive(0, 6'h00, 6'h00, 0, 1);

    // ADDIU then ANDI back-to-back, then idle.
    drive(1, 6'h09, 6'h00, 0, 1);
    drive(1, 6'h0C, 6'h00, 0, 1);
    drive(0, 6'h00, 6'h00, 0, 2);

    // RTYPE SLTU passthrough, REGIMM, undecodable opcode.
    drive(1, 6'h00, 6'h2B, 0, 1);
    drive(1, 6'h01, 6'h00, 0, 1);
    drive(1, 6'h3F, 6'h00, 0, 1);
    drive(0, 6'h00, 6'h00, 0, 2);

    // MULT, then in_valid held with ADDIU until the unit frees.
    drive(1, 6'h00, 6'h18, 0, 1);
    drive(1, 6'h09, 6'h00, 0, 8);
    drive(0, 6'h00, 6'h00, 0, 2);

    // DIVU with in_valid held high throughout.
    drive(1, 6'h00, 6'h1B, 0, 1);
    drive(1, 6'h0D, 6'h00, 0, 38);
    drive(0, 6'h00, 6'h00, 0, 2);

    // DIV flushed mid-operation.
    drive(1, 6'h00, 6'h1A, 0, 1);
    drive(0, 6'h00, 6'h00, 0, 9);
    drive(1, 6'h09, 6'h00, 1, 1);
    drive(0, 6'h00, 6'h00, 0, 40);

    // MULT interrupted by reset while busy.
    drive(1, 6'h00, 6'h19, 0, 1);
    drive(0, 6'h00, 6'h00, 0, 1);
    reset_n = 1'b0;
    drive(0, 6'h00, 6'h00, 0, 1);
    reset_n = 1'b1;
    drive(0, 6'h00, 6'h00, 0, 2);

    // Randomized traffic, mixing mult/div, illegal opcodes and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 9) < 3) begin
        opcode       = 6'h00;
        rtype_fncode = ($urandom_range(0, 1) == 0) ? md_fn[$urandom_range(0, 3)] : 6'($urandom());
      end else begin
        opcode       = 6'($urandom());
        rtype_fncode = 6'($urandom());
      end
      tick();
    end
    drive(0, 6'h00, 6'h00, 0, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
